// File: rtl/barrel_rotator_4bit_if.sv
// Capture-side bus of the 4-bit barrel rotator: operand, rotate control and qualified result.
interface barrel_rotator_4bit_if;
  logic [3:0] data_in;
  logic [1:0] rotate_amt;
  logic       dir;
  logic       in_valid;
  logic [3:0] data_out;
  logic       out_valid;

  modport master (
    output data_in,
    output rotate_amt,
    output dir,
    output in_valid,
    input  data_out,
    input  out_valid
  );

  modport slave (
    input  data_in,
    input  rotate_amt,
    input  dir,
    input  in_valid,
    output data_out,
    output out_valid
  );
endinterface

// File: rtl/barrel_rotator_4bit.sv
// Registered 4-bit barrel rotator: two-level log rotator (by 1, then by 2) into one output register.
module barrel_rotator_4bit (
  input  logic                        clk,
  input  logic                        rst,
  barrel_rotator_4bit_if.slave        bus
);

  logic [3:0] stage0;
  logic [3:0] stage1;
  logic [3:0] data_d, data_q;
  logic       valid_d, valid_q;

  always_comb begin
    stage0 = bus.data_in;
    if (bus.rotate_amt[0]) begin
      stage0 = bus.dir ? {bus.data_in[0], bus.data_in[3:1]}
                       : {bus.data_in[2:0], bus.data_in[3]};
    end
    // Rotating by 2 is the same in either direction, so no direction mux here.
    stage1 = bus.rotate_amt[1] ? {stage0[1:0], stage0[3:2]} : stage0;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      data_d  = stage1;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_barrel_rotator_4bit.sv
// Bench for barrel_rotator_4bit: vector table, exhaustive sweep and reset/hold sequences on a scoreboard.
module tb_barrel_rotator_4bit;

  typedef struct {
    logic [3:0] d;
    logic [1:0] a;
    logic       dir;
    logic [3:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];
  vec_t tbl[8];

  barrel_rotator_4bit_if bus ();

  barrel_rotator_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from the per-bit index definition.
  function automatic logic [3:0] rot_model(input logic [3:0] d, input int a, input bit dir);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = dir ? d[(i + a) % 4] : d[(i - a + 4) % 4];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic [1:0] a, input logic dir,
                       input logic [3:0] exp);
    @(posedge clk);
    #1;
    bus.data_in    = d;
    bus.rotate_amt = a;
    bus.dir        = dir;
    bus.in_valid   = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.data_in    = 4'($urandom);
    bus.rotate_amt = 2'($urandom);
    bus.dir        = 1'($urandom);
  endtask

  // Scoreboard monitor: every valid output consumes one expected word.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %b with out_valid=1, expected no output",
                 bus.data_out);
      end else begin
        chk("scoreboard", bus.data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{4'b1101, 2'd0, 1'b0, 4'b1101};
    tbl[1] = '{4'b1101, 2'd1, 1'b0, 4'b1011};
    tbl[2] = '{4'b1101, 2'd2, 1'b0, 4'b0111};
    tbl[3] = '{4'b1101, 2'd3, 1'b0, 4'b1110};
    tbl[4] = '{4'b1101, 2'd0, 1'b1, 4'b1101};
    tbl[5] = '{4'b1101, 2'd1, 1'b1, 4'b1110};
    tbl[6] = '{4'b1101, 2'd2, 1'b1, 4'b0111};
    tbl[7] = '{4'b1101, 2'd3, 1'b1, 4'b1011};

    // Reset held with valid input present.
    rst            = 1'b0;
    bus.data_in    = 4'b1101;
    bus.rotate_amt = 2'd1;
    bus.dir        = 1'b0;
    bus.in_valid   = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset_async_data", bus.data_out, 4'b0000);
    chk("reset_async_valid", {3'b000, bus.out_valid}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold_data", bus.data_out, 4'b0000);
      chk("reset_hold_valid", {3'b000, bus.out_valid}, 4'b0000);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    drive(4'b1101, 2'd1, 1'b0, 4'b1011);

    // Left and right sweeps from the vector table, back to back.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].d, tbl[i].a, tbl[i].dir, tbl[i].exp);
    end

    // Hold: output must survive five idle cycles with random inputs.
    drive(4'b1000, 2'd1, 1'b0, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      idle();
      @(negedge clk);
      chk("hold_data", bus.data_out, 4'b0001);
      if (i > 0) chk("hold_valid", {3'b000, bus.out_valid}, 4'b0000);
    end

    // Exhaustive sweep against the model.
    for (int d = 0; d < 16; d++) begin
      for (int a = 0; a < 4; a++) begin
        for (int r = 0; r < 2; r++) begin
          drive(4'(d), 2'(a), 1'(r), rot_model(4'(d), a, r[0]));
        end
      end
    end

    // Right by (4-a)%4 must reproduce left by a.
    for (int d = 0; d < 16; d += 3) begin
      for (int a = 0; a < 4; a++) begin
        drive(4'(d), 2'(a), 1'b0, rot_model(4'(d), a, 1'b0));
        drive(4'(d), 2'((4 - a) % 4), 1'b1, rot_model(4'(d), a, 1'b0));
      end
    end

    // Mid-stream reset between edges.
    drive(4'b0110, 2'd1, 1'b1, 4'b0011);
    drive(4'b1001, 2'd3, 1'b0, 4'b1100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midreset_data", bus.data_out, 4'b0000);
    chk("midreset_valid", {3'b000, bus.out_valid}, 4'b0000);
    @(negedge clk);
    chk("midreset_hold_data", bus.data_out, 4'b0000);
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    drive(4'b0010, 2'd2, 1'b0, 4'b1000);
    drive(4'b0111, 2'd1, 1'b1, 4'b1011);
    drive(4'b1110, 2'd3, 1'b1, 4'b1101);

    // Drain with a bounded wait.
    idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    chk("final_valid", {3'b000, bus.out_valid}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_rotator_4bit.md
# barrel_rotator_4bit

Registered 4-bit barrel rotator: rotates a 4-bit word left or right by 0–3 positions and presents the result on a registered output one clock later. Used as a small datapath primitive wherever bit-rotation by a run-time amount is needed, e.g. in shift/rotate units and bit-manipulation stages. Single clock domain; no internal state beyond the output pipeline register.

## Interface
- Parameters: none (width fixed at 4 bits, rotate amount fixed at 2 bits).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  4  word to rotate.
- rotate_amt  input  2  rotate distance, 0–3 positions, unsigned.
- dir  input  1  direction: 0 = rotate left (toward MSB), 1 = rotate right (toward LSB).
- in_valid  input  1  qualifies data_in/rotate_amt/dir for capture on this edge.
- data_out  output  4  registered rotated word.
- out_valid  output  1  high for exactly the cycles in which data_out holds a result captured on the previous edge with in_valid=1.

## Operation
- Combinational rotate function R(d, a, dir):
  - Left: R = {d[3-a:0], d[3:4-a]}; bit i of result = d[(i - a) mod 4].
  - Right: R = {d[a-1:0], d[3:a]}; bit i of result = d[(i + a) mod 4].
  - a = 0: R = d for either direction.
  - No bits lost or zero-filled; every output bit comes from data_in.
- Structure: two-level log rotator (stage 0 rotates by 1 when rotate_amt[0], stage 1 rotates by 2 when rotate_amt[1]); direction applied in each stage by muxing left vs right versions. Any equivalent mux structure is acceptable provided results match R.
- Right rotate by a is identical to left rotate by (4 - a) mod 4; rotate by 2 is direction-independent.
- On each rising clk with rst low:
  - in_valid=1: data_out <= R(data_in, rotate_amt, dir); out_valid <= 1.
  - in_valid=0: data_out holds its previous value; out_valid <= 0.
- No back-pressure: a new input may be accepted every cycle; the block never stalls.
- X/Z on inputs while in_valid=0 must not disturb data_out.

## Timing
- Latency: exactly 1 clock from capture edge (in_valid=1) to data_out/out_valid.
- Throughput: 1 result per clock.
- Reset: rst high forces data_out = 4'b0000 and out_valid = 0 immediately (asynchronous), held while rst is high regardless of clk/in_valid.
- Reset release: first capture occurs on the first rising clk edge after rst falls with in_valid=1; an edge coincident with rst deassertion is not required to capture.
- Reset mid-stream: any result in the output register is discarded; out_valid drops without waiting for clk.
- Inputs sampled only at rising clk; combinational path data_in/rotate_amt/dir -> output register is the only timing path; no combinational input-to-output path.

## Test plan
- Reset: assert rst with in_valid=1, data_in=4'b1101 -> data_out=0000, out_valid=0 asynchronously and through several clk edges; release -> next valid capture appears one clock later.
- Left sweep: data_in=1101, dir=0, in_valid=1, rotate_amt=0,1,2,3 on consecutive clocks -> data_out=1101, 1011, 0111, 1110 on the following consecutive clocks, out_valid=1 each.
- Right sweep: data_in=1101, dir=1, rotate_amt=0,1,2,3 -> data_out=1101, 1110, 0111, 1011.
- Hold: capture data_in=1000, dir=0, amt=1 (-> 0001), then in_valid=0 with data_in changing randomly for 5 cycles -> data_out stays 0001, out_valid=0 from the second cycle on.
- Exhaustive: all 16 data_in × 4 amt × 2 dir, back-to-back with in_valid=1 -> each data_out equals R one clock later; check left-a equals right-(4-a) mod 4.
- Mid-stream reset: stream valid inputs, pulse rst between clock edges -> data_out=0000 and out_valid=0 immediately; stream resumes correctly after release.
